// File: rtl/rr_packet_arbiter.sv
// Round-robin wormhole arbiter: drains flits from IN_N upstream FIFOs
// (one-cycle read latency) into a single registered output, holding the
// grant on one input from a head flit until its tail/single flit.
module rr_packet_arbiter #(
   parameter int DATA_W = 8,
   parameter int IN_N   = 4,
   parameter int ID     = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [IN_N-1:0]        empty_i,
   input  logic [IN_N*DATA_W-1:0] data_i,
   output logic [IN_N-1:0]        rd_en_o,
   output logic [DATA_W-1:0]      data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [IN_N-1:0]        grant_o,
   output logic                   err_o
);

   localparam int IDX_W = (IN_N > 1) ? $clog2(IN_N) : 1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      lock_q, lock_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic                  pend_q, pend_d;
   logic                  first_q, first_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  valid_q, valid_d;
   logic [IN_N-1:0]       grant_q, grant_d;
   logic                  err_q, err_d;

   logic [IN_N-1:0]       rd_en_s;
   logic                  found_s;
   logic [IDX_W-1:0]      sel_s;
   logic [IDX_W-1:0]      cand_s;
   logic [DATA_W-1:0]     cap_s;
   logic [1:0]            cap_type_s;
   logic                  out_free_s;

   // Flit presented by the locked FIFO during a capture cycle, and its type.
   assign cap_s      = data_i[lock_q*DATA_W +: DATA_W];
   assign cap_type_s = cap_s[DATA_W-1 -: 2];

   // Output register can take a new flit if empty or draining this cycle.
   assign out_free_s = !valid_q || ready_i;

   // Round-robin search: first non-empty input after the last one served.
   always_comb begin
      found_s = 1'b0;
      sel_s   = '0;
      cand_s  = '0;
      for (int i = 1; i <= IN_N; i++) begin
         cand_s = IDX_W'((int'(last_q) + i) % IN_N);
         if (!found_s && !empty_i[cand_s]) begin
            found_s = 1'b1;
            sel_s   = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic: capture of pending reads, arbitration and read issue.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      last_d  = last_q;
      pend_d  = pend_q;
      first_d = first_q;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      rd_en_s = '0;

      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (pend_q) begin
         // Reads are only issued into a free output register, so it is
         // guaranteed empty when the data arrives.
         data_d  = cap_s;
         valid_d = 1'b1;
         pend_d  = 1'b0;
         first_d = 1'b0;
         if (first_q && !cap_type_s[1]) begin
            err_d = 1'b1;          // packet started with body or tail
         end else if (!first_q && cap_type_s[1]) begin
            err_d = 1'b1;          // new head inside an open packet
         end else begin
            err_d = err_q;
         end
         if (cap_type_s[0]) begin
            state_d = ST_IDLE;     // tail or single closes the packet
         end else begin
            state_d = state_q;
         end
      end else if (out_free_s) begin
         case (state_q)
            ST_IDLE: begin
               if (found_s) begin
                  rd_en_s[sel_s] = 1'b1;
                  lock_d         = sel_s;
                  last_d         = sel_s;
                  pend_d         = 1'b1;
                  first_d        = 1'b1;
                  state_d        = ST_LOCKED;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOCKED: begin
               // An empty locked input simply stalls the packet.
               if (!empty_i[lock_q]) begin
                  rd_en_s[lock_q] = 1'b1;
                  pend_d          = 1'b1;
               end else begin
                  pend_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         rd_en_s = '0;
      end

      if (state_d == ST_LOCKED) begin
         grant_d = {{(IN_N-1){1'b0}}, 1'b1} << lock_d;
      end else begin
         grant_d = '0;
      end
   end

   // State and output registers; reset discards any in-flight read or flit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
         last_q  <= IDX_W'(IN_N - 1);
         pend_q  <= 1'b0;
         first_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         first_q <= first_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
         err_q   <= err_d;
      end
   end

   // Read enables must follow empty_i in the same cycle; reset masks them.
   assign rd_en_o = rd_en_s & {IN_N{rst_ni}};
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign grant_o = grant_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter with behavioural one-cycle-latency
// FIFO models on each input.
module tb_rr_packet_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [3:0]  empty_i;
   logic [31:0] data_i;
   logic [3:0]  rd_en_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic [3:0]  grant_o;
   logic        err_o;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] mem   [4][16];
   int         wr_p  [4];
   int         rd_p  [4];
   logic [7:0] rdata [4];

   typedef struct {
      logic        rdy;
      logic [3:0]  push;
      logic [31:0] pval;
      logic [3:0]  rd;
      logic        vld;
      logic [7:0]  dat;
      logic [3:0]  gnt;
      logic        err;
   } vec_t;

   vec_t tbl [34];

   rr_packet_arbiter #(.DATA_W(8), .IN_N(4), .ID(0)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .empty_i (empty_i),
      .data_i  (data_i),
      .rd_en_o (rd_en_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .grant_o (grant_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   // FIFO models: read data appears the cycle after rd_en.
   always @(posedge clk_i) begin
      for (int k = 0; k < 4; k++) begin
         if (rd_en_o[k]) begin
            rdata[k] <= mem[k][rd_p[k] % 16];
            rd_p[k]  <= rd_p[k] + 1;
         end
      end
   end

   // FIFO flags and data as seen by the arbiter.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         empty_i[k]         = (wr_p[k] == rd_p[k]);
         data_i[k*8 +: 8]   = rdata[k];
      end
   end

   task automatic push(input int k, input logic [7:0] v);
      mem[k][wr_p[k] % 16] = v;
      wr_p[k] = wr_p[k] + 1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] rd, input logic vld,
                          input logic [7:0] dat, input logic [3:0] gnt, input logic err);
      chk({tag, " rd_en"}, 32'(rd_en_o), 32'(rd));
      chk({tag, " valid"}, 32'(valid_o), 32'(vld));
      chk({tag, " data"},  32'(data_o),  32'(dat));
      chk({tag, " grant"}, 32'(grant_o), 32'(gnt));
      chk({tag, " err"},   32'(err_o),   32'(err));
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         wr_p[k]  = 0;
         rd_p[k]  = 0;
         rdata[k] = 8'h00;
      end
      // Round robin, then FIFO0 served after FIFO3 on wrap.
      tbl[0]  = '{1'b1, 4'b1111, 32'hC3C2C1C0, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0};
      tbl[1]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'h00, 4'b0001, 1'b0};
      tbl[2]  = '{1'b1, 4'b0000, 32'h0,        4'b0010, 1'b1, 8'hC0, 4'b0000, 1'b0};
      tbl[3]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC0, 4'b0010, 1'b0};
      tbl[4]  = '{1'b1, 4'b0000, 32'h0,        4'b0100, 1'b1, 8'hC1, 4'b0000, 1'b0};
      tbl[5]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC1, 4'b0100, 1'b0};
      tbl[6]  = '{1'b1, 4'b0000, 32'h0,        4'b1000, 1'b1, 8'hC2, 4'b0000, 1'b0};
      tbl[7]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC2, 4'b1000, 1'b0};
      tbl[8]  = '{1'b1, 4'b1001, 32'hC70000C4, 4'b0001, 1'b1, 8'hC3, 4'b0000, 1'b0};
      tbl[9]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC3, 4'b0001, 1'b0};
      tbl[10] = '{1'b1, 4'b0000, 32'h0,        4'b1000, 1'b1, 8'hC4, 4'b0000, 1'b0};
      tbl[11] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC4, 4'b1000, 1'b0};
      tbl[12] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b1, 8'hC7, 4'b0000, 1'b0};
      tbl[13] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC7, 4'b0000, 1'b0};
      // Wormhole lock: FIFO0 packet 81,02,43 before FIFO1 single C9.
      tbl[14] = '{1'b1, 4'b0011, 32'h0000C981, 4'b0001, 1'b0, 8'hC7, 4'b0000, 1'b0};
      tbl[15] = '{1'b1, 4'b0001, 32'h00000002, 4'b0000, 1'b0, 8'hC7, 4'b0001, 1'b0};
      tbl[16] = '{1'b1, 4'b0001, 32'h00000043, 4'b0001, 1'b1, 8'h81, 4'b0001, 1'b0};
      tbl[17] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'h81, 4'b0001, 1'b0};
      tbl[18] = '{1'b1, 4'b0000, 32'h0,        4'b0001, 1'b1, 8'h02, 4'b0001, 1'b0};
      tbl[19] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'h02, 4'b0001, 1'b0};
      tbl[20] = '{1'b1, 4'b0000, 32'h0,        4'b0010, 1'b1, 8'h43, 4'b0000, 1'b0};
      tbl[21] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'h43, 4'b0010, 1'b0};
      tbl[22] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b1, 8'hC9, 4'b0000, 1'b0};
      // Backpressure: five stalled cycles holding C2, then FIFO3 resumes.
      tbl[23] = '{1'b1, 4'b1100, 32'hC3C20000, 4'b0100, 1'b0, 8'hC9, 4'b0000, 1'b0};
      tbl[24] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC9, 4'b0100, 1'b0};
      for (int i = 25; i < 30; i++) begin
         tbl[i] = '{1'b0, 4'b0000, 32'h0,      4'b0000, 1'b1, 8'hC2, 4'b0000, 1'b0};
      end
      tbl[30] = '{1'b1, 4'b0000, 32'h0,        4'b1000, 1'b1, 8'hC2, 4'b0000, 1'b0};
      tbl[31] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC2, 4'b1000, 1'b0};
      tbl[32] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b1, 8'hC3, 4'b0000, 1'b0};
      tbl[33] = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 8'hC3, 4'b0000, 1'b0};

      // Reset state.
      rst_ni  = 1'b0;
      ready_i = 1'b1;
      tick();
      #1 chk_all("reset", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
      tick();
      rst_ni = 1'b1;

      for (int i = 0; i < 34; i++) begin
         tick();
         ready_i = tbl[i].rdy;
         for (int k = 0; k < 4; k++) begin
            if (tbl[i].push[k]) begin
               push(k, tbl[i].pval[k*8 +: 8]);
            end
         end
         #1 chk_all($sformatf("row%0d", i), tbl[i].rd, tbl[i].vld, tbl[i].dat,
                    tbl[i].gnt, tbl[i].err);
      end

      // Protocol error: FIFO3 opens with a body flit, closed by a tail.
      tick(); push(3, 8'h05);
      #1 chk_all("err0", 4'b1000, 1'b0, 8'hC3, 4'b0000, 1'b0);
      tick();
      #1 chk_all("err1", 4'b0000, 1'b0, 8'hC3, 4'b1000, 1'b0);
      tick(); push(3, 8'h45);
      #1 chk_all("err2", 4'b1000, 1'b1, 8'h05, 4'b1000, 1'b1);
      tick();
      #1 chk_all("err3", 4'b0000, 1'b0, 8'h05, 4'b1000, 1'b1);
      tick();
      #1 chk_all("err4", 4'b0000, 1'b1, 8'h45, 4'b0000, 1'b1);
      tick();
      #1 chk_all("err5", 4'b0000, 1'b0, 8'h45, 4'b0000, 1'b1);

      // Reset one cycle after a head capture; FIFO0 regains the grant first.
      tick(); push(0, 8'h81); push(0, 8'h02); push(1, 8'hC1);
      #1 chk_all("mrst0", 4'b0001, 1'b0, 8'h45, 4'b0000, 1'b1);
      tick();
      #1 chk_all("mrst1", 4'b0000, 1'b0, 8'h45, 4'b0001, 1'b1);
      tick();
      #1 chk_all("mrst2", 4'b0001, 1'b1, 8'h81, 4'b0001, 1'b1);
      #1 rst_ni = 1'b0;
      #1 chk_all("mrst_in", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
      tick();
      #1 chk_all("mrst_hold", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
      tick();
      rst_ni = 1'b1;
      #1 chk_all("mrst_rel0", 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0);
      tick();
      #1 chk_all("mrst_rel1", 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b0);
      tick();
      #1 chk_all("mrst_rel2", 4'b0000, 1'b1, 8'h02, 4'b0001, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
